// File: rtl/word_finder_kmp_pkg.sv
// word_finder_kmp_pkg: shared state encoding, character constants and case folding
package word_finder_kmp_pkg;
    typedef enum logic [1:0] {IDLE, BUILD, RUN} state_t;
    localparam logic [7:0] CH_A = 8'h41, CH_Z = 8'h5A, CASE_BIT = 8'h20;
    function automatic logic [31:0] fold_case(input logic [31:0] c);
        return (c >= 32'(CH_A) && c <= 32'(CH_Z)) ? c | 32'(CASE_BIT) : c;
    endfunction
endpackage

// File: rtl/word_finder_kmp_if.sv
// word_finder_kmp_if: configuration and character-stream signals of the word finder
interface word_finder_kmp_if #(
    parameter int MAX_LEN = 16,
    parameter int CHAR_W = 8,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(MAX_LEN)
);
    logic cfg_clr, cfg_we, cfg_build, nocase, overlap;
    logic [AW-1:0] cfg_addr;
    logic [CHAR_W-1:0] cfg_char;
    logic [AW:0] cfg_len;
    logic in_valid, in_ready, match, busy, armed;
    logic [CHAR_W-1:0] letter;
    logic [CNT_W-1:0] match_cnt;
    modport master (
        output cfg_clr, cfg_we, cfg_addr, cfg_char, cfg_len, cfg_build, nocase, overlap, in_valid, letter,
        input in_ready, match, match_cnt, busy, armed
    );
    modport slave (
        input cfg_clr, cfg_we, cfg_addr, cfg_char, cfg_len, cfg_build, nocase, overlap, in_valid, letter,
        output in_ready, match, match_cnt, busy, armed
    );
endinterface

// File: rtl/kmp_fail_builder.sv
// kmp_fail_builder: computes the KMP failure table one step per cycle after start
module kmp_fail_builder #(
    parameter int MAX_LEN = 16,
    parameter int CHAR_W = 8,
    localparam int AW = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [AW:0]       len,
    input  logic [CHAR_W-1:0] pat [MAX_LEN],
    output logic [AW-1:0]     fail [MAX_LEN],
    output logic              done
);
    logic run;
    logic [AW:0] i;
    logic [AW-1:0] k;
    assign done = run && i == len;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            run <= 1'b0;
            i <= '0;
            k <= '0;
            fail <= '{default: '0};
        end else if (abort) run <= 1'b0;
        else if (start) begin
            run <= 1'b1;
            i <= (AW+1)'(1);
            k <= '0;
            fail[0] <= '0;
        end else if (run) begin
            if (i == len) run <= 1'b0;
            else if (pat[AW'(i)] == pat[k]) begin
                k <= k + AW'(1);
                fail[AW'(i)] <= k + AW'(1);
                i <= i + (AW+1)'(1);
            end else if (k != '0) k <= fail[k - AW'(1)];
            else begin
                fail[AW'(i)] <= '0;
                i <= i + (AW+1)'(1);
            end
        end
endmodule

// File: rtl/word_finder_kmp.sv
// word_finder_kmp: streaming KMP matcher with loadable pattern, overlap/nocase modes and saturating count
module word_finder_kmp
    import word_finder_kmp_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CHAR_W = 8,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(MAX_LEN)
) (
    input logic clk,
    input logic rst_n,
    word_finder_kmp_if.slave bus
);
    state_t st, nxt;
    logic [CHAR_W-1:0] p [MAX_LEN];
    logic [CHAR_W-1:0] pf [MAX_LEN];
    logic [AW-1:0] fail [MAX_LEN];
    logic [AW:0] len_q, j, jn, len_c;
    logic nc_q, ov_q, hold_v, done, bld, eq, fb, res, hit, match_q;
    logic [CHAR_W-1:0] hold_c;
    logic [CNT_W-1:0] cnt;

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c, input logic en);
        return en ? CHAR_W'(fold_case(32'(c))) : c;
    endfunction

    kmp_fail_builder #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) u_fb (
        .clk(clk), .rst_n(rst_n), .start(bld), .abort(bus.cfg_clr),
        .len(len_q), .pat(pf), .fail(fail), .done(done)
    );

    always_comb begin
        for (int n = 0; n < MAX_LEN; n++) pf[n] = fold(p[n], nc_q);
        len_c = bus.cfg_len > (AW+1)'(MAX_LEN) ? (AW+1)'(MAX_LEN) : bus.cfg_len;
        bld = !bus.cfg_clr && bus.cfg_build && bus.cfg_len != '0 && st != BUILD;
        nxt = bus.cfg_clr ? IDLE : bld ? BUILD : (st == BUILD && done) ? RUN : st;
        // a mismatch with j>0 falls back and keeps the letter held for another compare
        eq = hold_v && hold_c == pf[AW'(j)];
        fb = hold_v && !eq && j != '0;
        res = hold_v && !fb;
        jn = j + (AW+1)'(eq);
        hit = res && jn == len_q;
        bus.in_ready = st == RUN && (!hold_v || res);
    end

    assign bus.busy = st == BUILD;
    assign bus.armed = st == RUN;
    assign bus.match = match_q;
    assign bus.match_cnt = cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            p <= '{default: '0};
            len_q <= '0;
            nc_q <= 1'b0;
            ov_q <= 1'b0;
            j <= '0;
            hold_v <= 1'b0;
            hold_c <= '0;
            match_q <= 1'b0;
            cnt <= '0;
        end else begin
            if (bus.cfg_we && st == IDLE) p[bus.cfg_addr] <= bus.cfg_char;
            if (bld) begin
                len_q <= len_c;
                nc_q <= bus.nocase;
                ov_q <= bus.overlap;
            end
            if (bus.cfg_clr || bld) begin
                j <= '0;
                hold_v <= 1'b0;
                match_q <= 1'b0;
                cnt <= '0;
            end else begin
                match_q <= hit;
                if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
                j <= fb ? {1'b0, fail[AW'(j - (AW+1)'(1))]} :
                     hit ? (ov_q ? {1'b0, fail[AW'(len_q - (AW+1)'(1))]} : '0) : jn;
                if (bus.in_valid && bus.in_ready) begin
                    hold_v <= 1'b1;
                    hold_c <= fold(bus.letter, nc_q);
                end else if (res) hold_v <= 1'b0;
            end
        end
endmodule

// File: tb/tb_word_finder_kmp.sv
// tb_word_finder_kmp: directed checks of pattern load, table build, matching modes, saturation and reset
module tb_word_finder_kmp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0, errs = 0, nmatch = 0, stalls = 0;

    always #5 clk = ~clk;

    word_finder_kmp_if #(.MAX_LEN(16), .CHAR_W(8), .CNT_W(2)) bf ();
    word_finder_kmp #(.MAX_LEN(16), .CHAR_W(8), .CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bf));

    always @(negedge clk) if (bf.match) nmatch++;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bf.cfg_clr = 1'b1;
        @(negedge clk);
        bf.cfg_clr = 1'b0;
    endtask

    task automatic load(input string s);
        clr();
        for (int i = 0; i < s.len(); i++) begin
            bf.cfg_we = 1'b1;
            bf.cfg_addr = 4'(i);
            bf.cfg_char = s[i];
            @(negedge clk);
        end
        bf.cfg_we = 1'b0;
    endtask

    task automatic build(input int len, input logic nc, input logic ov);
        int n = 0;
        bf.cfg_len = 5'(len);
        bf.nocase = nc;
        bf.overlap = ov;
        bf.cfg_build = 1'b1;
        @(negedge clk);
        bf.cfg_build = 1'b0;
        while (!bf.armed && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("armed_after_build", int'(bf.armed), 1);
    endtask

    task automatic send(input byte c);
        int n = 0;
        bf.letter = c;
        bf.in_valid = 1'b1;
        #1;
        while (!bf.in_ready && n < 20) begin
            stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("send_timeout", n, 0);
        @(negedge clk);
        bf.in_valid = 1'b0;
    endtask

    task automatic stream(input string s);
        nmatch = 0;
        stalls = 0;
        for (int i = 0; i < s.len(); i++) send(s[i]);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bf.cfg_clr = 0; bf.cfg_we = 0; bf.cfg_addr = 0; bf.cfg_char = 0; bf.cfg_len = 0;
        bf.cfg_build = 0; bf.nocase = 0; bf.overlap = 0; bf.in_valid = 0; bf.letter = 0;
        #1;
        check("rst_armed", int'(bf.armed), 0);
        check("rst_busy", int'(bf.busy), 0);
        check("rst_match", int'(bf.match), 0);
        check("rst_cnt", int'(bf.match_cnt), 0);
        check("rst_ready", int'(bf.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load("POOJITHA");
        build(8, 0, 0);
        check("t1_fail7", int'(dut.u_fb.fail[7]), 0);
        stream("XXPOOJITHAP");
        check("t1_matches", nmatch, 1);
        check("t1_cnt", int'(bf.match_cnt), 1);

        load("ABAB");
        build(4, 0, 1);
        check("t2_fail2", int'(dut.u_fb.fail[2]), 1);
        check("t2_fail3", int'(dut.u_fb.fail[3]), 2);
        stream("ABABAB");
        check("t2_ov_matches", nmatch, 2);
        check("t2_ov_cnt", int'(bf.match_cnt), 2);
        build(4, 0, 0);
        stream("ABABAB");
        check("t2_nov_matches", nmatch, 1);
        check("t2_nov_cnt", int'(bf.match_cnt), 1);

        load("AAB");
        build(3, 0, 0);
        check("t3_fail0", int'(dut.u_fb.fail[0]), 0);
        check("t3_fail1", int'(dut.u_fb.fail[1]), 1);
        check("t3_fail2", int'(dut.u_fb.fail[2]), 0);
        stream("AAAB");
        check("t3_stalls", stalls, 1);
        check("t3_matches", nmatch, 1);

        load("poojitha");
        build(8, 1, 0);
        stream("PoOjItHa");
        check("t4_nocase_matches", nmatch, 1);
        build(8, 0, 0);
        stream("PoOjItHa");
        check("t4_case_matches", nmatch, 0);
        check("t4_case_cnt", int'(bf.match_cnt), 0);

        load("AB");
        build(2, 0, 1);
        stream("ABABABABAB");
        check("t5_matches", nmatch, 5);
        check("t5_sat_cnt", int'(bf.match_cnt), 3);

        load("POOJITHA");
        build(8, 0, 0);
        send("P"); send("O"); send("O"); send("J");
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_armed", int'(bf.armed), 0);
        check("t5_rst_ready", int'(bf.in_ready), 0);
        check("t5_rst_cnt", int'(bf.match_cnt), 0);
        check("t5_rst_match", int'(bf.match), 0);
        check("t5_rst_j", int'(dut.j), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build(8, 0, 0);
        stream("POOJITHA");
        check("t5_noreload_matches", nmatch, 0);

        clr();
        bf.cfg_len = 0;
        bf.cfg_build = 1'b1;
        @(negedge clk);
        bf.cfg_build = 1'b0;
        @(negedge clk);
        check("t6_len0_busy", int'(bf.busy), 0);
        check("t6_len0_armed", int'(bf.armed), 0);

        load("ABAB");
        bf.letter = "A";
        bf.in_valid = 1'b1;
        bf.cfg_len = 4;
        bf.overlap = 0;
        bf.cfg_build = 1'b1;
        @(negedge clk);
        bf.cfg_build = 1'b0;
        check("t6_busy", int'(bf.busy), 1);
        check("t6_ready_build", int'(bf.in_ready), 0);
        for (int n = 0; n < 40 && !bf.armed; n++) @(negedge clk);
        bf.in_valid = 1'b0;
        check("t6_armed", int'(bf.armed), 1);
        check("t6_no_accept", int'(dut.hold_v), 0);
        bf.cfg_we = 1'b1;
        bf.cfg_addr = 0;
        bf.cfg_char = "Z";
        @(negedge clk);
        bf.cfg_we = 1'b0;
        stream("ABAB");
        check("t6_we_ignored_matches", nmatch, 1);
        check("t6_we_ignored_cnt", int'(bf.match_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
